// File: rtl/water_dispenser_pkg.sv
// Shared definitions for the water dispenser payout path: coin table and FSM states.
package water_dispenser_pkg;

   localparam int unsigned COIN_COUNT = 6;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      EMIT,
      DONE,
      FAULT
   } state_t;

   // Coin value in cents by denomination index; indices 6 and 7 are unused.
   function automatic logic [7:0] coin_value(input logic [2:0] idx);
      case (idx)
         3'd0:    coin_value = 8'd1;
         3'd1:    coin_value = 8'd5;
         3'd2:    coin_value = 8'd10;
         3'd3:    coin_value = 8'd25;
         3'd4:    coin_value = 8'd50;
         3'd5:    coin_value = 8'd100;
         default: coin_value = 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_selector.sv
// Combinational greedy pick: largest denomination that fits the remaining amount and is in stock.
module coin_selector
   import water_dispenser_pkg::*;
#(
   parameter int unsigned AMOUNT_WIDTH = 16,
   parameter int unsigned STOCK_WIDTH  = 8
) (
   input  logic [AMOUNT_WIDTH-1:0] remaining,
   input  logic [STOCK_WIDTH-1:0]  stock [COIN_COUNT],
   output logic                    hit,
   output logic [2:0]              index
);

   logic [AMOUNT_WIDTH-1:0] value;

   // Ascending scan, so the last qualifying entry (largest value) wins.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      value = '0;
      for (int unsigned i = 0; i < COIN_COUNT; i++) begin
         value = AMOUNT_WIDTH'(coin_value(3'(i)));
         if ((value <= remaining) && (stock[i] != '0)) begin
            hit   = 1'b1;
            index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Payout FSM: pays a change amount one coin at a time over valid/ready, limited by per-coin stock.
module change_dispenser
   import water_dispenser_pkg::*;
#(
   parameter int unsigned AMOUNT_WIDTH  = 16,
   parameter int unsigned STOCK_WIDTH   = 8,
   parameter int unsigned INITIAL_STOCK = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AMOUNT_WIDTH-1:0] amount,
   input  logic                    cancel,
   input  logic                    refill,
   input  logic                    coin_ready,
   output logic                    coin_valid,
   output logic [2:0]              coin_index,
   output logic [AMOUNT_WIDTH-1:0] remaining,
   output logic                    busy,
   output logic                    done,
   output logic                    fault
);

   state_t                  state;
   logic [STOCK_WIDTH-1:0]  stock [COIN_COUNT];
   logic                    sel_hit;
   logic [2:0]              sel_index;
   logic [AMOUNT_WIDTH-1:0] emit_value;
   logic [AMOUNT_WIDTH-1:0] next_remaining;

   coin_selector #(
      .AMOUNT_WIDTH(AMOUNT_WIDTH),
      .STOCK_WIDTH (STOCK_WIDTH)
   ) u_coin_selector (
      .remaining(remaining),
      .stock    (stock),
      .hit      (sel_hit),
      .index    (sel_index)
   );

   always_comb begin
      emit_value     = AMOUNT_WIDTH'(coin_value(coin_index));
      next_remaining = remaining - emit_value;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         remaining  <= '0;
         coin_valid <= 1'b0;
         coin_index <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         for (int unsigned i = 0; i < COIN_COUNT; i++) stock[i] <= STOCK_WIDTH'(INITIAL_STOCK);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= amount;
                  busy      <= 1'b1;
                  if (amount == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SELECT;
                  end
               end else if (refill) begin
                  for (int unsigned i = 0; i < COIN_COUNT; i++) stock[i] <= STOCK_WIDTH'(INITIAL_STOCK);
               end
            end
            SELECT: begin
               if (cancel) begin
                  state     <= IDLE;
                  remaining <= '0;
                  busy      <= 1'b0;
               end else if (sel_hit) begin
                  state      <= EMIT;
                  coin_index <= sel_index;
                  coin_valid <= 1'b1;
               end else begin
                  state <= FAULT;
                  fault <= 1'b1;
               end
            end
            EMIT: begin
               // cancel beats a simultaneous coin_ready: the coin is not counted
               if (cancel) begin
                  state      <= IDLE;
                  remaining  <= '0;
                  coin_valid <= 1'b0;
                  busy       <= 1'b0;
               end else if (coin_ready) begin
                  coin_valid <= 1'b0;
                  remaining  <= next_remaining;
                  if (stock[coin_index] != '0) stock[coin_index] <= stock[coin_index] - 1'b1;
                  if (next_remaining == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SELECT;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            FAULT: begin
               if (cancel) begin
                  state     <= IDLE;
                  remaining <= '0;
                  fault     <= 1'b0;
                  busy      <= 1'b0;
               end else if (refill) begin
                  state <= SELECT;
                  fault <= 1'b0;
                  for (int unsigned i = 0; i < COIN_COUNT; i++) stock[i] <= STOCK_WIDTH'(INITIAL_STOCK);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table with a coin scoreboard plus corner-case sequences.
module tb_change_dispenser;

   logic        clock = 1'b0;
   logic        reset;
   logic        start, cancel, refill, coin_ready;
   logic [15:0] amount;
   logic        coin_valid, busy, done, fault;
   logic [2:0]  coin_index;
   logic [15:0] remaining;

   logic        b_start, b_cancel, b_refill, b_coin_ready;
   logic [15:0] b_amount;
   logic        b_coin_valid, b_busy, b_done, b_fault;
   logic [2:0]  b_coin_index;
   logic [15:0] b_remaining;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int done_cnt  = 0;
   int valid_cnt = 0;

   always #5 clock = ~clock;

   change_dispenser #(.AMOUNT_WIDTH(16), .STOCK_WIDTH(8), .INITIAL_STOCK(8)) dut_a (
      .clock(clock), .reset(reset), .start(start), .amount(amount), .cancel(cancel),
      .refill(refill), .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_index(coin_index),
      .remaining(remaining), .busy(busy), .done(done), .fault(fault)
   );

   change_dispenser #(.AMOUNT_WIDTH(16), .STOCK_WIDTH(8), .INITIAL_STOCK(2)) dut_b (
      .clock(clock), .reset(reset), .start(b_start), .amount(b_amount), .cancel(b_cancel),
      .refill(b_refill), .coin_ready(b_coin_ready), .coin_valid(b_coin_valid), .coin_index(b_coin_index),
      .remaining(b_remaining), .busy(b_busy), .done(b_done), .fault(b_fault)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: a coin is accepted on the next rising edge when valid & ready & !cancel.
   always @(negedge clock) begin
      if (reset) begin
         if (done) done_cnt++;
         if (coin_valid) valid_cnt++;
         if (coin_valid && coin_ready && !cancel) begin
            if (exp_q.size() == 0) begin
               check("unexpected_coin", 32'(coin_index), 32'hFFFF_FFFF);
            end else begin
               check("coin_index", 32'(coin_index), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   typedef struct {
      int amount;
      int n;
      int coins[8];
      bit rand_ready;
   } vec_t;

   vec_t vecs[5];

   task automatic wait_idle(input string name);
      int n;
      for (n = 0; n < 200; n++) begin
         tick();
         if (coin_valid || !busy) coin_ready = coin_ready;
         if (!busy) break;
      end
      if (n == 200) check({name, "_timeout"}, 32'(n), 32'(0));
   endtask

   initial begin
      int d0, v0, n, got0, got1;
      vecs[0] = '{87,  5, '{4, 3, 2, 0, 0, 0, 0, 0}, 1'b0};
      vecs[1] = '{0,   0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0};
      vecs[2] = '{186, 5, '{5, 4, 3, 2, 0, 0, 0, 0}, 1'b1};
      vecs[3] = '{17,  4, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b1};
      vecs[4] = '{99,  8, '{4, 3, 2, 2, 0, 0, 0, 0}, 1'b1};

      reset = 1'b0; start = 0; cancel = 0; refill = 0; coin_ready = 0; amount = '0;
      b_start = 0; b_cancel = 0; b_refill = 0; b_coin_ready = 0; b_amount = '0;
      #12;
      check("reset_valid", 32'(coin_valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_remaining", 32'(remaining), 0);
      check("reset_stock0", 32'(dut_a.stock[0]), 8);
      tick();
      reset = 1'b1;
      tick();

      // Small-stock DUT: 3 cents with two 1-cent coins faults at 1 cent owed.
      b_coin_ready = 1; b_amount = 16'd3; b_start = 1;
      tick();
      b_start = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (b_coin_valid) begin
            if (n == 0) got0 = 32'(b_coin_index); else got1 = 32'(b_coin_index);
            n++;
         end
         if (b_fault) break;
         tick();
      end
      check("b_coin_count", 32'(n), 2);
      check("b_coin0", 32'(got0), 0);
      check("b_coin1", 32'(got1), 0);
      check("b_fault", 32'(b_fault), 1);
      check("b_fault_remaining", 32'(b_remaining), 1);
      tick(); tick();
      check("b_fault_held", 32'(b_fault), 1);
      b_refill = 1;
      tick();
      b_refill = 0;
      n = 0; got0 = 9; d0 = 0;
      for (int i = 0; i < 20; i++) begin
         if (b_coin_valid) begin got0 = 32'(b_coin_index); n++; end
         if (b_done) begin d0 = 1; break; end
         tick();
      end
      check("b_refill_coins", 32'(n), 1);
      check("b_refill_index", 32'(got0), 0);
      check("b_refill_done", 32'(d0), 1);
      check("b_refill_remaining", 32'(b_remaining), 0);
      // Fault again, then cancel and refill together: cancel wins and stock stays empty.
      tick();
      b_start = 1;
      tick();
      b_start = 0;
      for (int i = 0; i < 20; i++) begin
         if (b_fault) break;
         tick();
      end
      check("b_fault2", 32'(b_fault), 1);
      b_cancel = 1; b_refill = 1;
      tick();
      b_cancel = 0; b_refill = 0;
      check("b_cancel_fault", 32'(b_fault), 0);
      check("b_cancel_busy", 32'(b_busy), 0);
      check("b_cancel_remaining", 32'(b_remaining), 0);
      check("b_cancel_beats_refill", 32'(dut_b.stock[0]), 0);

      // Vector table on the default-stock DUT.
      for (int v = 0; v < 5; v++) begin
         refill = 1;
         tick();
         refill = 0;
         for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].coins[k]);
         d0 = done_cnt; v0 = valid_cnt;
         amount = 16'(vecs[v].amount); start = 1; coin_ready = 1;
         tick();
         start = 0;
         for (n = 0; n < 200; n++) begin
            if (vecs[v].rand_ready) coin_ready = 1'($urandom_range(0, 1));
            tick();
            if (!busy) break;
         end
         coin_ready = 0;
         if (n == 200) check("vec_timeout", 32'(n), 0);
         check("vec_done_pulses", 32'(done_cnt - d0), 1);
         check("vec_queue_empty", 32'(exp_q.size()), 0);
         check("vec_remaining", 32'(remaining), 0);
         if (vecs[v].amount == 0) check("zero_no_valid", 32'(valid_cnt - v0), 0);
         exp_q.delete();
      end

      // Stalled ejector: 25-cent coin held stable, then 25 + 5 paid.
      refill = 1;
      tick();
      refill = 0;
      exp_q.push_back(3); exp_q.push_back(1);
      d0 = done_cnt;
      amount = 16'd30; start = 1; coin_ready = 0;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(coin_valid), 1);
         check("stall_index", 32'(coin_index), 3);
         tick();
      end
      coin_ready = 1;
      for (n = 0; n < 50; n++) begin
         tick();
         if (!busy) break;
      end
      coin_ready = 0;
      check("stall_done", 32'(done_cnt - d0), 1);
      check("stall_queue_empty", 32'(exp_q.size()), 0);
      check("stall_stock3", 32'(dut_a.stock[3]), 7);

      // Reset mid-EMIT; start is ignored while busy.
      amount = 16'd50; start = 1;
      tick();
      start = 0;
      tick();
      amount = 16'd5; start = 1;
      tick();
      start = 0;
      check("busy_start_ignored_rem", 32'(remaining), 50);
      check("busy_start_ignored_idx", 32'(coin_index), 4);
      #3 reset = 1'b0;
      #1;
      check("async_reset_valid", 32'(coin_valid), 0);
      check("async_reset_busy", 32'(busy), 0);
      check("async_reset_remaining", 32'(remaining), 0);
      check("async_reset_index", 32'(coin_index), 0);
      check("async_reset_stock3", 32'(dut_a.stock[3]), 8);
      tick();
      reset = 1'b1;
      tick();

      // Cancel on the same edge as coin_ready in EMIT: no coin, no done.
      d0 = done_cnt;
      amount = 16'd100; start = 1;
      tick();
      start = 0;
      tick();
      check("cancel_pre_index", 32'(coin_index), 5);
      cancel = 1; coin_ready = 1;
      tick();
      cancel = 0; coin_ready = 0;
      check("cancel_busy", 32'(busy), 0);
      check("cancel_remaining", 32'(remaining), 0);
      check("cancel_valid", 32'(coin_valid), 0);
      check("cancel_stock5", 32'(dut_a.stock[5]), 8);
      tick(); tick();
      check("cancel_no_done", 32'(done_cnt - d0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
